// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage RV32I core.
// Drives the F/D and D/E stage-register hold/flush controls, the Execute
// operand forwarding selects, and a data-memory wait FSM (RUN, MEM_WAIT,
// TIMEOUT) that freezes the whole pipeline and has a timeout watchdog.
// Saturating counters track stall and flush cycles.
//
// Optional feature: define HAZARD_FORWARDING_EN to enable operand forwarding
// from Memory/Writeback. When it is undefined, the forwarding selects stay
// at 00. Decode then also stalls on any Execute or Memory producer of its
// source registers.
//
// Memory handshake: memReq_M is held by the Memory stage for as long as its
// access is outstanding. memReady high in a cycle completes that access in
// the same cycle. Every cycle with memReq_M=1 and memReady=0 is a wait
// cycle, and the pipeline is frozen during it.
//
// state_dbg exposes the FSM state: 0 = RUN, 1 = MEM_WAIT, 2 = TIMEOUT.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        rs1_D,
    input  logic [4:0]        rs2_D,
    input  logic [4:0]        rs1_E,
    input  logic [4:0]        rs2_E,
    input  logic [4:0]        rd_E,
    input  logic [4:0]        rd_M,
    input  logic [4:0]        rd_W,
    input  logic              regWrite_E,
    input  logic              regWrite_M,
    input  logic              regWrite_W,
    input  logic              load_E,
    input  logic              pcSrc_E,
    input  logic              memReq_M,
    input  logic              memReady,
    output logic              stall_F,
    output logic              enn_FD,
    output logic              clr_FD,
    output logic              clr_DE,
    output logic              freeze,
    output logic [1:0]        forwardA_E,
    output logic [1:0]        forwardB_E,
    output logic              memErr,
    output logic [PERF_W-1:0] stallCnt,
    output logic [PERF_W-1:0] flushCnt,
    output logic [1:0]        state_dbg
);

    localparam int WCW = $clog2(MEM_TIMEOUT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
    logic           mem_stall;
    logic           dec_stall;

    // Register x0 never takes part in a hazard or forwarding match.
    function automatic logic hit(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

    assign mem_stall = memReq_M & ~memReady;
    assign state_dbg = state;

`ifdef HAZARD_FORWARDING_EN
    // Memory has priority over Writeback because it holds the younger value.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic wr_m, input logic [4:0] rdm,
                                           input logic wr_w, input logic [4:0] rdw);
        if (wr_m && hit(rdm, rs))
            return 2'b10;
        else if (wr_w && hit(rdw, rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Only a load in Execute cannot be forwarded in time for Decode.
    assign dec_stall = load_E & regWrite_E & (hit(rd_E, rs1_D) | hit(rd_E, rs2_D));
`else
    // Without forwarding, Decode waits out any in-flight producer in E or M.
    // Writeback matches are resolved by the write-first register file.
    assign dec_stall = (load_E & regWrite_E & (hit(rd_E, rs1_D) | hit(rd_E, rs2_D)))
                     | (regWrite_E & (hit(rd_E, rs1_D) | hit(rd_E, rs2_D)))
                     | (regWrite_M & (hit(rd_M, rs1_D) | hit(rd_M, rs2_D)));

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{rs1_E, rs2_E, rd_W, regWrite_W};
`endif

    // Memory wait FSM next state and wait counter.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        case (state)
            RUN: begin
                if (mem_stall)
                    state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (memReady)
                    state_nxt = RUN;
                else if (wait_cnt == WAIT_LAST)
                    state_nxt = TIMEOUT;
                else
                    wait_cnt_nxt = wait_cnt + 1'b1;
            end
            TIMEOUT: state_nxt = TIMEOUT;
            default: state_nxt = RUN;
        endcase
    end

    // FSM state, wait counter and the sticky watchdog error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            memErr   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            memErr   <= memErr | (state_nxt == TIMEOUT);
        end
    end

    // Hazard response: freeze beats a taken branch, and a taken branch beats a Decode stall.
    always_comb begin
        stall_F    = 1'b0;
        enn_FD     = 1'b0;
        clr_FD     = 1'b0;
        clr_DE     = 1'b0;
        freeze     = 1'b0;
        forwardA_E = 2'b00;
        forwardB_E = 2'b00;
        if (reset) begin
            freeze = (state == TIMEOUT) | mem_stall;
`ifdef HAZARD_FORWARDING_EN
            forwardA_E = fwd_sel(rs1_E, regWrite_M, rd_M, regWrite_W, rd_W);
            forwardB_E = fwd_sel(rs2_E, regWrite_M, rd_M, regWrite_W, rd_W);
`endif
            if (freeze) begin
                // The flush is deferred; pcSrc_E stays held while frozen.
                stall_F = 1'b1;
                enn_FD  = 1'b1;
            end else if (pcSrc_E) begin
                clr_FD = 1'b1;
                clr_DE = 1'b1;
            end else if (dec_stall) begin
                stall_F = 1'b1;
                enn_FD  = 1'b1;
                clr_DE  = 1'b1;
            end
        end
    end

    // Saturating stall and flush cycle counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stall_F && (stallCnt != '1))
                stallCnt <= stallCnt + 1'b1;
            if (clr_FD && (flushCnt != '1))
                flushCnt <= flushCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test-plan sequences plus randomized traffic.
// Every cycle is checked against a behavioural model of the controller.
module tb_hazard_ctrl;

    localparam int MT   = 8;
    localparam int PW   = 4;
    localparam int CMAX = (1 << PW) - 1;

    // Clock and reset.
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic regWrite_E, regWrite_M, regWrite_W, load_E, pcSrc_E, memReq_M, memReady;
    logic stall_F, enn_FD, clr_FD, clr_DE, freeze, memErr;
    logic [1:0] forwardA_E, forwardB_E, state_dbg;
    logic [PW-1:0] stallCnt, flushCnt;

    hazard_ctrl #(.MEM_TIMEOUT(MT), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
        .regWrite_E(regWrite_E), .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
        .load_E(load_E), .pcSrc_E(pcSrc_E), .memReq_M(memReq_M), .memReady(memReady),
        .stall_F(stall_F), .enn_FD(enn_FD), .clr_FD(clr_FD), .clr_DE(clr_DE),
        .freeze(freeze), .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
        .memErr(memErr), .stallCnt(stallCnt), .flushCnt(flushCnt),
        .state_dbg(state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: whether a memory wait is in progress, how many wait cycles
    // have elapsed, whether the watchdog fired, and the two counters.
    bit m_wait, m_tout, m_err;
    int m_wcyc, m_scnt, m_fcnt;
    bit e_stall, e_enn, e_cfd, e_cde, e_frz;
    int e_fa, e_fb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

    function automatic int fwd(input logic [4:0] rs);
        if (regWrite_M && hit(rd_M, rs)) return 2;
        if (regWrite_W && hit(rd_W, rs)) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_tout = 0; m_err = 0;
        m_wcyc = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    // Expected combinational outputs from the current inputs and the model state.
    task automatic predict();
        bit hz;
        e_frz = m_tout || (memReq_M && !memReady);
        hz = load_E && regWrite_E && (hit(rd_E, rs1_D) || hit(rd_E, rs2_D));
`ifdef HAZARD_FORWARDING_EN
        e_fa = fwd(rs1_E);
        e_fb = fwd(rs2_E);
`else
        e_fa = 0;
        e_fb = 0;
        hz = hz || (regWrite_E && (hit(rd_E, rs1_D) || hit(rd_E, rs2_D)))
                || (regWrite_M && (hit(rd_M, rs1_D) || hit(rd_M, rs2_D)));
`endif
        e_stall = 0; e_enn = 0; e_cfd = 0; e_cde = 0;
        if (e_frz) begin
            e_stall = 1; e_enn = 1;
        end else if (pcSrc_E) begin
            e_cfd = 1; e_cde = 1;
        end else if (hz) begin
            e_stall = 1; e_enn = 1; e_cde = 1;
        end
    endtask

    // Model update at the rising edge.
    task automatic advance();
        if (e_stall) m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
        if (e_cfd)   m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
        if (!m_tout) begin
            if (!m_wait) begin
                if (memReq_M && !memReady) begin
                    m_wait = 1;
                    m_wcyc = 0;
                end
            end else if (memReady) begin
                m_wait = 0;
            end else begin
                m_wcyc++;
                if (m_wcyc == MT) begin
                    m_tout = 1;
                    m_err  = 1;
                    m_wait = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("stall_F", 32'(stall_F), 32'(e_stall));
        check("enn_FD", 32'(enn_FD), 32'(e_enn));
        check("clr_FD", 32'(clr_FD), 32'(e_cfd));
        check("clr_DE", 32'(clr_DE), 32'(e_cde));
        check("freeze", 32'(freeze), 32'(e_frz));
        check("forwardA_E", 32'(forwardA_E), e_fa);
        check("forwardB_E", 32'(forwardB_E), e_fb);
        check("memErr", 32'(memErr), 32'(m_err));
        check("stallCnt", 32'(stallCnt), m_scnt);
        check("flushCnt", 32'(flushCnt), m_fcnt);
        check("in_run", 32'(state_dbg == 2'd0), 32'(!m_wait && !m_tout));
    endtask

    // One cycle: inputs already applied just after the previous rising edge.
    task automatic step();
        predict();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall_F"}, 32'(stall_F), 0);
        check({tag, "_enn_FD"}, 32'(enn_FD), 0);
        check({tag, "_clr_FD"}, 32'(clr_FD), 0);
        check({tag, "_clr_DE"}, 32'(clr_DE), 0);
        check({tag, "_freeze"}, 32'(freeze), 0);
        check({tag, "_fwdA"}, 32'(forwardA_E), 0);
        check({tag, "_fwdB"}, 32'(forwardB_E), 0);
        check({tag, "_memErr"}, 32'(memErr), 0);
        check({tag, "_stallCnt"}, 32'(stallCnt), 0);
        check({tag, "_flushCnt"}, 32'(flushCnt), 0);
        check({tag, "_in_run"}, 32'(state_dbg == 2'd0), 1);
    endtask

    // Asynchronous reset pulse placed between clock edges; inputs are left as they are.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs({tag, "_async"});
        @(negedge clk);
        check_reset_outputs({tag, "_held"});
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    // Driver tasks.
    task automatic idle();
        rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
        regWrite_E = 0; regWrite_M = 0; regWrite_W = 0;
        load_E = 0; pcSrc_E = 0; memReq_M = 0; memReady = 0;
    endtask

    task automatic rand_inputs();
        rs1_D = 5'($urandom_range(0, 3)); rs2_D = 5'($urandom_range(0, 3));
        rs1_E = 5'($urandom_range(0, 3)); rs2_E = 5'($urandom_range(0, 3));
        rd_E  = 5'($urandom_range(0, 3)); rd_M  = 5'($urandom_range(0, 3));
        rd_W  = 5'($urandom_range(0, 3));
        regWrite_E = 1'($urandom_range(0, 1));
        regWrite_M = 1'($urandom_range(0, 1));
        regWrite_W = 1'($urandom_range(0, 1));
        load_E     = 1'($urandom_range(0, 1));
        pcSrc_E    = ($urandom_range(0, 4) == 0);
        memReq_M   = ($urandom_range(0, 3) == 0);
        memReady   = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        idle();
        model_reset();
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Load-use: one stall cycle, then the bubble releases it.
        load_E = 1; regWrite_E = 1; rd_E = 5; rs1_D = 5;
        step();
        idle(); rs1_D = 5;
        step();
        check("lu_stallCnt", 32'(stallCnt), 1);

        // Forwarding priority M > W, then W, then x0.
        regWrite_M = 1; rd_M = 3; regWrite_W = 1; rd_W = 3; rs1_E = 3; rs2_E = 3;
        step();
        rd_M = 0;
        step();
        rs1_E = 0;
        step();

        // Taken branch overrides load-use.
        idle();
        load_E = 1; regWrite_E = 1; rd_E = 5; rs1_D = 5; pcSrc_E = 1;
        step();

        // Three wait cycles with a held branch, flushed on the ready cycle.
        idle();
        memReq_M = 1; memReady = 0; pcSrc_E = 1;
        repeat (3) step();
        memReady = 1;
        step();
        idle();
        step();

        // Ready in the first request cycle: no freeze, no wait.
        memReq_M = 1; memReady = 1;
        step();

        // Decode dependence on a Memory-stage producer.
        idle();
        regWrite_M = 1; rd_M = 7; rs2_D = 7;
        step();

        // Counter saturation on both counters.
        idle();
        load_E = 1; regWrite_E = 1; rd_E = 9; rs2_D = 9;
        repeat (CMAX + 3) step();
        idle(); pcSrc_E = 1;
        repeat (CMAX + 3) step();
        check("sat_stallCnt", 32'(stallCnt), CMAX);
        check("sat_flushCnt", 32'(flushCnt), CMAX);

        do_reset("rst1");

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            step();
        end
        do_reset("rst2");

        // Reset in the middle of a wait.
        idle(); memReq_M = 1; memReady = 0;
        repeat (3) step();
        do_reset("rst_wait");

        // Watchdog timeout, then random traffic while stuck in TIMEOUT.
        idle(); memReq_M = 1; memReady = 0; pcSrc_E = 1;
        repeat (MT + 4) step();
        check("tout_memErr", 32'(memErr), 1);
        check("tout_freeze", 32'(freeze), 1);
        for (int i = 0; i < 40; i++) begin
            rand_inputs();
            step();
        end
        do_reset("rst_tout");

        for (int i = 0; i < 200; i++) begin
            rand_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
